// File: rtl/fetch_sync_pkg.sv
// Shared defaults and channel indices for the fetch redirect synchronizer.
package fetch_sync_pkg;

    localparam int unsigned FRS_NUM_CH = 2;
    localparam int unsigned FRS_WIDTH  = 16;
    localparam int unsigned FRS_DEPTH  = 2;

    localparam int unsigned FRS_CH_IP = 0;
    localparam int unsigned FRS_CH_CS = 1;

endpackage

// File: rtl/redirect_fifo.sv
// Synchronous commit FIFO; a push into a full FIFO with no pop merges into the youngest entry.
module redirect_fifo
    import fetch_sync_pkg::*;
#(
    parameter int unsigned NUM_CH = FRS_NUM_CH,
    parameter int unsigned WIDTH  = FRS_WIDTH,
    parameter int unsigned DEPTH  = FRS_DEPTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [NUM_CH*WIDTH-1:0] push_data_i,
    input  logic [NUM_CH-1:0]       push_mask_i,
    input  logic                    pop_i,
    output logic [NUM_CH*WIDTH-1:0] head_data_o,
    output logic [NUM_CH-1:0]       head_mask_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [NUM_CH*WIDTH-1:0] mem_data_q [DEPTH];
    logic [NUM_CH*WIDTH-1:0] mem_data_d [DEPTH];
    logic [NUM_CH-1:0]       mem_mask_q [DEPTH];
    logic [NUM_CH-1:0]       mem_mask_d [DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, yng_ptr;
    logic [CntW-1:0]         count_q, count_d;
    logic                    do_pop, do_push, do_merge;

    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CntW'(DEPTH));
    assign head_data_o = empty_o ? '0 : mem_data_q[rd_ptr_q];
    assign head_mask_o = empty_o ? '0 : mem_mask_q[rd_ptr_q];

    assign do_pop   = pop_i & ~empty_o;
    assign do_merge = push_i & full_o & ~do_pop;
    assign do_push  = push_i & ~do_merge;
    assign yng_ptr  = (wr_ptr_q == '0) ? PtrW'(DEPTH - 1) : wr_ptr_q - 1'b1;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_mask_d = mem_mask_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CntW'(do_push) - CntW'(do_pop);
        if (do_merge) begin
            // Newer channel values overwrite, untouched channels keep the older record's data.
            mem_mask_d[yng_ptr] = mem_mask_q[yng_ptr] | push_mask_i;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (push_mask_i[c]) begin
                    mem_data_d[yng_ptr][c*WIDTH +: WIDTH] = push_data_i[c*WIDTH +: WIDTH];
                end
            end
        end else if (do_push) begin
            mem_data_d[wr_ptr_q] = push_data_i;
            mem_mask_d[wr_ptr_q] = push_mask_i;
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_mask_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_data_q <= mem_data_d;
            mem_mask_q <= mem_mask_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/fetch_redirect_sync.sv
// Stages per-channel fetch redirect updates and commits them as records on propagate.
// Define FETCH_REDIRECT_BYPASS_EN for a zero-latency path when the commit FIFO is empty.
module fetch_redirect_sync
    import fetch_sync_pkg::*;
#(
    parameter int unsigned NUM_CH = FRS_NUM_CH,
    parameter int unsigned WIDTH  = FRS_WIDTH,
    parameter int unsigned DEPTH  = FRS_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       upd,
    input  logic [NUM_CH*WIDTH-1:0] upd_data,
    input  logic [NUM_CH*WIDTH-1:0] cur_data,
    input  logic                    propagate,
    input  logic                    abort,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [NUM_CH-1:0]       out_mask,
    output logic                    pending,
    output logic                    full
);

    logic [NUM_CH-1:0]       staged_q, staged_d;
    logic [NUM_CH*WIDTH-1:0] staged_val_q, staged_val_d;
    logic [NUM_CH-1:0]       rec_mask;
    logic [NUM_CH*WIDTH-1:0] rec_data;
    logic                    rec_push, fifo_push, fifo_empty;
    logic [NUM_CH*WIDTH-1:0] head_data;
    logic [NUM_CH-1:0]       head_mask;

    always_comb begin
        staged_d     = staged_q;
        staged_val_d = staged_val_q;
        rec_mask     = staged_q | upd;
        rec_data     = cur_data;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (upd[c]) begin
                rec_data[c*WIDTH +: WIDTH] = upd_data[c*WIDTH +: WIDTH];
            end else if (staged_q[c]) begin
                rec_data[c*WIDTH +: WIDTH] = staged_val_q[c*WIDTH +: WIDTH];
            end
        end
        if (abort || propagate) begin
            staged_d = '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (upd[c]) begin
                    staged_d[c] = 1'b1;
                    staged_val_d[c*WIDTH +: WIDTH] = upd_data[c*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign rec_push = propagate & ~abort & (|rec_mask);
    assign pending  = |staged_q;

`ifdef FETCH_REDIRECT_BYPASS_EN
    logic bypass;
    // A record consumed in its own propagate cycle never enters the FIFO.
    assign bypass    = rec_push & fifo_empty;
    assign fifo_push = rec_push & ~(bypass & out_ready);
    assign out_valid = ~fifo_empty | bypass;
    assign out_data  = bypass ? rec_data : head_data;
    assign out_mask  = bypass ? rec_mask : head_mask;
`else
    assign fifo_push = rec_push;
    assign out_valid = ~fifo_empty;
    assign out_data  = head_data;
    assign out_mask  = head_mask;
`endif

    redirect_fifo #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (fifo_push),
        .push_data_i (rec_data),
        .push_mask_i (rec_mask),
        .pop_i       (out_ready),
        .head_data_o (head_data),
        .head_mask_o (head_mask),
        .empty_o     (fifo_empty),
        .full_o      (full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            staged_q     <= '0;
            staged_val_q <= '0;
        end else begin
            staged_q     <= staged_d;
            staged_val_q <= staged_val_d;
        end
    end

endmodule

// File: tb/tb_fetch_redirect_sync.sv
// Scoreboard bench for fetch_redirect_sync: queue-based reference model, negedge monitor.
module tb_fetch_redirect_sync;
    import fetch_sync_pkg::*;

    localparam int NC = 2;
    localparam int W  = 16;
    localparam int D  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NC-1:0]   upd;
    logic [NC*W-1:0] upd_data, cur_data;
    logic            propagate, abort, out_ready;
    logic            out_valid;
    logic [NC*W-1:0] out_data;
    logic [NC-1:0]   out_mask;
    logic            pending, full;

    always #5 clk = ~clk;

    fetch_redirect_sync #(
        .NUM_CH (NC),
        .WIDTH  (W),
        .DEPTH  (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .upd       (upd),
        .upd_data  (upd_data),
        .cur_data  (cur_data),
        .propagate (propagate),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .pending   (pending),
        .full      (full)
    );

    typedef struct {
        logic [NC*W-1:0] data;
        logic [NC-1:0]   mask;
    } rec_t;

    rec_t          exp_q[$];
    logic [W-1:0]  st_val[NC];
    logic [NC-1:0] st_flag;
    int            checks = 0;
    int            failures = 0;
    bit            mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: compares outputs with the model's queue head and retires handshaked records.
    always @(negedge clk) begin
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0].data);
                check("out_mask", 32'(out_mask), 32'(exp_q[0].mask));
            end else begin
                check("out_data_idle", out_data, 32'h0);
                check("out_mask_idle", 32'(out_mask), 32'h0);
            end
            check("full", 32'(full), 32'(exp_q.size() == D));
            check("pending", 32'(pending), 32'(|st_flag));
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // Drive one cycle and apply its architectural effect to the model at the clock edge.
    task automatic step(input logic [NC-1:0] u, input logic [NC*W-1:0] ud,
                        input logic [NC*W-1:0] cd, input logic p, input logic a,
                        input logic r, input logic rs);
        rec_t rec;
        int   sz;
        bit   popping, do_push;
        upd = u; upd_data = ud; cur_data = cd;
        propagate = p; abort = a; out_ready = r; reset = rs;
        sz = exp_q.size();
        popping = r && (sz > 0);
        do_push = 1'b0;
        rec.data = '0;
        rec.mask = '0;
        if (rs && !a && p) begin
            for (int c = 0; c < NC; c++) begin
                rec.mask[c] = st_flag[c] | u[c];
                if (u[c])            rec.data[c*W +: W] = ud[c*W +: W];
                else if (st_flag[c]) rec.data[c*W +: W] = st_val[c];
                else                 rec.data[c*W +: W] = cd[c*W +: W];
            end
            do_push = (rec.mask != '0);
        end
        @(posedge clk);
        if (!rs) begin
            exp_q.delete();
            st_flag = '0;
            for (int c = 0; c < NC; c++) st_val[c] = '0;
        end else begin
            if (a || p) begin
                st_flag = '0;
            end else begin
                for (int c = 0; c < NC; c++) begin
                    if (u[c]) begin
                        st_flag[c] = 1'b1;
                        st_val[c]  = ud[c*W +: W];
                    end
                end
            end
            if (do_push) begin
                if (sz == D && !popping) begin
                    rec_t y;
                    y = exp_q[exp_q.size()-1];
                    for (int c = 0; c < NC; c++) begin
                        if (rec.mask[c]) y.data[c*W +: W] = rec.data[c*W +: W];
                    end
                    y.mask = y.mask | rec.mask;
                    exp_q[exp_q.size()-1] = y;
                end else begin
                    exp_q.push_back(rec);
                end
            end
        end
        #1;
    endtask

    task automatic idle(input logic r);
        step('0, '0, '0, 1'b0, 1'b0, r, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) idle(1'b1);
    endtask

    initial begin
        st_flag = '0;
        for (int c = 0; c < NC; c++) st_val[c] = '0;
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        idle(1'b0);

        // Two channels staged in separate cycles, committed together.
        step(2'b01, 32'h0000_1234, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(2'b10, 32'hF000_0000, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step('0, '0, 32'hAAAA_BBBB, 1'b1, 1'b0, 1'b0, 1'b1);
        check("d037_valid", 32'(out_valid), 32'h1);
        check("d037_data", out_data, 32'hF000_1234);
        check("d037_mask", 32'(out_mask), 32'h3);
        drain();

        // Empty propagate produces nothing.
        step('0, '0, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 1'b1);
        check("d038_valid", 32'(out_valid), 32'h0);

        // Last staged write loses to a same-cycle update; ch1 comes from cur_data.
        step(2'b01, 32'h0000_0010, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h0000_0020, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h0000_0030, 32'h0700_0999, 1'b1, 1'b0, 1'b0, 1'b1);
        check("d039_data", out_data, 32'h0700_0030);
        check("d039_mask", 32'(out_mask), 32'h1);
        drain();

        // Abort discards staging, and wins over a same-cycle propagate.
        step(2'b01, 32'h0000_5555, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        step('0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
        step('0, '0, '0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("d040_valid_a", 32'(out_valid), 32'h0);
        step(2'b01, 32'h0000_5555, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(2'b10, 32'h6666_0000, '0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("d040_valid_b", 32'(out_valid), 32'h0);
        check("d040_pending", 32'(pending), 32'h0);

        // Back-pressure: third commit merges into the youngest entry.
        step(2'b01, 32'h0000_0001, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b10, 32'h0002_0000, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h0000_0003, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("d041_full", 32'(full), 32'h1);
        check("d041_head", out_data, 32'h0000_0001);
        idle(1'b1);
        check("d041_second_data", out_data, 32'h0002_0003);
        check("d041_second_mask", 32'(out_mask), 32'h3);
        drain();

        // Reset with entries queued and a channel staged.
        step(2'b01, 32'h0000_0011, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b10, 32'h0022_0000, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(2'b01, 32'h0000_0033, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("d042_valid", 32'(out_valid), 32'h0);
        check("d042_pending", 32'(pending), 32'h0);
        step('0, '0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
        check("d042_no_record", 32'(out_valid), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(NC'($urandom_range(0, 3)), $urandom, $urandom,
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) != 0));
        end
        drain();

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_sync.md
FETCH_REDIRECT_SYNC -- requirements
Module: fetch_redirect_sync

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of independently updated channels (channel 0 = IP, channel 1 = CS).
REQ-002 SHALL have parameter WIDTH, default 16: bits per channel.
REQ-003 SHALL have parameter DEPTH, default 2: number of commit FIFO entries, minimum 1.
REQ-004 SHALL have port clk, in, 1: the single clock.
REQ-005 SHALL have port reset, in, 1: synchronous, active-low.
REQ-006 SHALL have port upd, in, NUM_CH: per-channel update strobes.
REQ-007 SHALL have port upd_data, in, NUM_CH*WIDTH: new channel values, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port cur_data, in, NUM_CH*WIDTH: live architectural channel values.
REQ-009 SHALL have port propagate, in, 1: microinstruction complete; commit point.
REQ-010 SHALL have port abort, in, 1: discard all staged updates.
REQ-011 SHALL have port out_valid, out, 1: commit record available.
REQ-012 SHALL have port out_ready, in, 1: the prefetcher accepts the record.
REQ-013 SHALL have port out_data, out, NUM_CH*WIDTH: committed values for all channels.
REQ-014 SHALL have port out_mask, out, NUM_CH: channels changed in this record.
REQ-015 SHALL have port pending, out, 1: at least one staged flag is set.
REQ-016 SHALL have port full, out, 1: the commit FIFO holds DEPTH entries.

Function
REQ-017 SHALL stage upd_data[i] and set staged[i] on any cycle with upd[i]=1 and propagate=0 and abort=0; the last write wins.
REQ-018 SHALL form a commit record on a propagate=1, abort=0 cycle: mask[i] = staged[i]|upd[i]; data[i] = upd_data[i] if upd[i], else the staged value if staged[i], else cur_data[i].
REQ-019 SHALL clear all staged flags on any propagate=1 or abort=1 cycle.
REQ-020 SHALL not push a record when its mask is zero.
REQ-021 SHALL give priority to abort over propagate in the same cycle: no commit occurs and staged flags clear.
REQ-022 SHALL ignore upd in any cycle with abort=1.
REQ-023 SHALL push a non-empty record into the FIFO; out_valid rises in cycle N+1 after a propagate in cycle N.
REQ-024 SHALL drive out_valid from FIFO-not-empty, with out_data and out_mask taken from the FIFO head; the head pops on out_valid&out_ready.
REQ-025 SHALL hold out_data and out_mask stable while out_valid=1 and out_ready=0.
REQ-026 SHALL merge a push into the youngest entry when the FIFO is full with no pop that cycle: mask is ORed, data replaced for the new mask bits, count unchanged.
REQ-027 SHALL perform a normal push with no merge when the FIFO is full and a pop occurs in the same cycle.
REQ-028 SHALL hold out_data and out_mask at zero when the FIFO is empty.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, clear staged flags and staged values, empty the FIFO, and drive out_valid=0, out_data=0, out_mask=0, pending=0, full=0.
REQ-030 SHALL discard in-flight entries on a mid-operation reset, with no partial record emitted.

Configuration
REQ-031 SHALL support macro FETCH_REDIRECT_BYPASS_EN.
REQ-032 SHALL, with FETCH_REDIRECT_BYPASS_EN defined and the FIFO empty, present a commit record on out_valid/out_data/out_mask in the propagate cycle itself (zero latency).
REQ-033 SHALL, with FETCH_REDIRECT_BYPASS_EN defined, discard a bypassed record consumed with out_ready=1 in that cycle, and enqueue it otherwise.
REQ-034 SHALL, without FETCH_REDIRECT_BYPASS_EN, have all outputs registered with 1-cycle latency per REQ-023.

Structure
REQ-035 SHALL place the default constants FRS_NUM_CH, FRS_WIDTH and FRS_DEPTH, plus the channel index constants FRS_CH_IP=0 and FRS_CH_CS=1, in package fetch_sync_pkg.
REQ-036 SHALL implement the FIFO as sub-module redirect_fifo: a synchronous FIFO with a tail-merge port; pointers wrap modulo DEPTH.

Verification
(NUM_CH=2, WIDTH=16, DEPTH=2)
REQ-037 SHALL cover: upd ch0=0x1234 at c1, upd ch1=0xF000 at c3, propagate at c5 -> c6 out_valid=1, data {0xF000,0x1234}, mask 2'b11.
REQ-038 SHALL cover: propagate with no upd and nothing staged -> out_valid remains 0.
REQ-039 SHALL cover: stage ch0 0x0010 then 0x0020, then propagate with upd ch0=0x0030, cur ch1=0x0700 -> data {0x0700,0x0030}, mask 2'b01.
REQ-040 SHALL cover: stage ch0 0x5555, abort, propagate -> no record; stage again, then abort+propagate same cycle -> no record, pending=0.
REQ-041 SHALL cover: out_ready=0 with commits {ch0=0x0001}, {ch1=0x0002}, {ch0=0x0003} -> full=1, two entries, second entry data {0x0002,0x0003}, mask 2'b11.
REQ-042 SHALL cover: two entries queued plus ch0 staged, reset=0 for one cycle -> out_valid=0, pending=0; a following propagate with no upd produces no record.
